counting_bloom: RTL and testbench

- Counting Bloom filter: the removal-capable counterpart of the insert-only bit-vector Bloom filter.
- Each bucket holds a saturating counter instead of a single bit, so a previously inserted key can be removed as well as inserted and checked.
- Driven by a valid/ready request channel and a valid/ready response channel, so a control FSM elsewhere in the core can issue membership and removal operations.

---
 rtl/counting_bloom_if.sv | 27 ++
 rtl/counting_bloom.sv | 197 +++++++++++++++++++
 tb/tb_counting_bloom.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/counting_bloom_if.sv
// Request/response channel of the counting Bloom filter, plus its occupancy and
// saturation status. The filter is the slave; the issuing controller is the master.
interface counting_bloom_if #(
  parameter int d_size    = 32,
  parameter int hash_size = 5
);
  logic                 req_valid;
  logic                 req_ready;
  logic [1:0]           req_op;
  logic [d_size-1:0]    req_data;
  logic                 resp_valid;
  logic                 resp_ready;
  logic                 resp_match;
  logic                 resp_err;
  logic [hash_size:0]   occupancy;
  logic                 saturated;

  modport slave (
    input  req_valid, req_op, req_data, resp_ready,
    output req_ready, resp_valid, resp_match, resp_err, occupancy, saturated
  );

  modport master (
    output req_valid, req_op, req_data, resp_ready,
    input  req_ready, resp_valid, resp_match, resp_err, occupancy, saturated
  );
endinterface

// File: rtl/counting_bloom.sv
// Counting Bloom filter: two XOR-fold hashes index a bank of saturating counters,
// supporting check / insert / remove / clear with one operation in flight.
module counting_bloom #(
  parameter int d_size    = 32,
  parameter int bl_size   = 32,
  parameter int hash_size = 5,
  parameter int cnt_width = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  counting_bloom_if.slave  bus
);

  localparam int NCHUNK = (d_size + hash_size - 1) / hash_size;
  localparam int PAD_W  = NCHUNK * hash_size;
  localparam int OCC_W  = hash_size + 1;
  localparam logic [cnt_width-1:0] CMAX = '1;

  localparam logic [1:0] OP_CHECK  = 2'b00;
  localparam logic [1:0] OP_INSERT = 2'b01;
  localparam logic [1:0] OP_REMOVE = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HASH,
    S_UPDATE,
    S_RESP
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             op_q, op_d;
  logic [d_size-1:0]      key_q, key_d;
  logic [hash_size-1:0]   h0_q, h0_d;
  logic [hash_size-1:0]   h1_q, h1_d;
  logic                   match_q, match_d;
  logic                   err_q, err_d;
  logic [OCC_W-1:0]       occ_q, occ_d;
  logic                   sat_q, sat_d;
  logic [cnt_width-1:0]   cnt_q [bl_size];
  logic [cnt_width-1:0]   cnt_d [bl_size];

  logic [d_size-1:0]      key_rev;
  logic [hash_size-1:0]   hash0, hash1;
  logic [cnt_width-1:0]   c0, c1, n0, n1;
  logic                   same, pre_match;
  logic                   wr0, wr1, clr;

  // XOR of all hash_size-wide chunks; the key is zero-padded at the top first.
  function automatic logic [hash_size-1:0] fold(input logic [PAD_W-1:0] v);
    logic [hash_size-1:0] acc;
    acc = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      acc = acc ^ v[i*hash_size +: hash_size];
    end
    return acc;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < d_size; gi++) begin : g_rev
      assign key_rev[gi] = key_q[d_size-1-gi];
    end
  endgenerate

  assign hash0 = fold(PAD_W'(key_q));
  assign hash1 = fold(PAD_W'(key_rev));

  assign c0        = cnt_q[h0_q];
  assign c1        = cnt_q[h1_q];
  assign same      = (h0_q == h1_q);
  assign pre_match = (c0 != '0) && (c1 != '0);

  // A bucket at CMAX is frozen in both directions so saturation stays sticky per bucket.
  assign n0 = (c0 == CMAX) ? c0 :
              (op_q == OP_INSERT) ? c0 + 1'b1 : c0 - 1'b1;
  assign n1 = (c1 == CMAX) ? c1 :
              (op_q == OP_INSERT) ? c1 + 1'b1 : c1 - 1'b1;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    key_d   = key_q;
    h0_d    = h0_q;
    h1_d    = h1_q;
    match_d = match_q;
    err_d   = err_q;
    occ_d   = occ_q;
    sat_d   = sat_q;
    wr0     = 1'b0;
    wr1     = 1'b0;
    clr     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          op_d    = bus.req_op;
          key_d   = bus.req_data;
          state_d = S_HASH;
        end
      end
      S_HASH: begin
        h0_d    = hash0;
        h1_d    = hash1;
        state_d = S_UPDATE;
      end
      S_UPDATE: begin
        match_d = pre_match;
        err_d   = 1'b0;
        state_d = S_RESP;
        case (op_q)
          OP_INSERT: begin
            wr0   = 1'b1;
            wr1   = !same;
            occ_d = occ_q + OCC_W'(c0 == '0) + OCC_W'(!same && (c1 == '0));
            if ((n0 == CMAX) || (n1 == CMAX)) begin
              sat_d = 1'b1;
            end
          end
          OP_REMOVE: begin
            if (!pre_match) begin
              err_d = 1'b1;
            end else begin
              wr0   = 1'b1;
              wr1   = !same;
              occ_d = occ_q - OCC_W'(n0 == '0) - OCC_W'(!same && (n1 == '0));
            end
          end
          OP_CLEAR: begin
            clr     = 1'b1;
            occ_d   = '0;
            sat_d   = 1'b0;
            match_d = 1'b0;
          end
          default: begin
          end
        endcase
      end
      S_RESP: begin
        if (bus.resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  generate
    for (gi = 0; gi < bl_size; gi++) begin : g_bucket
      localparam logic [hash_size-1:0] IDX = hash_size'(gi);
      assign cnt_d[gi] = clr                       ? '0 :
                         (wr0 && (h0_q == IDX))    ? n0 :
                         (wr1 && (h1_q == IDX))    ? n1 : cnt_q[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < bl_size; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_CHECK;
      key_q   <= '0;
      h0_q    <= '0;
      h1_q    <= '0;
      match_q <= 1'b0;
      err_q   <= 1'b0;
      occ_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      key_q   <= key_d;
      h0_q    <= h0_d;
      h1_q    <= h1_d;
      match_q <= match_d;
      err_q   <= err_d;
      occ_q   <= occ_d;
      sat_q   <= sat_d;
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.resp_match = match_q;
  assign bus.resp_err   = err_q;
  assign bus.occupancy  = occ_q;
  assign bus.saturated  = sat_q;

endmodule

// File: tb/tb_counting_bloom.sv
// Directed plus randomized bench for counting_bloom against a bucket-array model.
module tb_counting_bloom;

  localparam logic [1:0] OP_CHECK  = 2'b00;
  localparam logic [1:0] OP_INSERT = 2'b01;
  localparam logic [1:0] OP_REMOVE = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  logic clk = 1'b0;
  logic reset_n;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   last_acc = 0;
  bit   b2b = 0;

  int   mc [32];
  bit   msat;

  counting_bloom_if #(.d_size(32), .hash_size(5)) bus ();

  counting_bloom #(
    .d_size(32), .bl_size(32), .hash_size(5), .cnt_width(4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Key zero-extended to 35 bits, then every 5-bit chunk XORed together.
  function automatic int fold35(input logic [34:0] v);
    int r = 0;
    for (int i = 0; i < 7; i++) r = r ^ int'((v >> (5 * i)) & 35'd31);
    return r;
  endfunction

  function automatic int mhash0(input logic [31:0] k);
    return fold35({3'b000, k});
  endfunction

  function automatic int mhash1(input logic [31:0] k);
    logic [34:0] v = '0;
    for (int i = 0; i < 32; i++) v[i] = k[31 - i];
    return fold35(v);
  endfunction

  function automatic int mocc();
    int n = 0;
    for (int i = 0; i < 32; i++) if (mc[i] != 0) n++;
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mc[i] = 0;
    msat = 0;
  endtask

  task automatic model_apply(input logic [1:0] op, input logic [31:0] key,
                             output bit m, output bit e);
    int a = mhash0(key);
    int b = mhash1(key);
    m = (mc[a] != 0) && (mc[b] != 0);
    e = 0;
    case (op)
      OP_INSERT: begin
        if (mc[a] < 15) mc[a]++;
        if (b != a && mc[b] < 15) mc[b]++;
        if (mc[a] == 15 || mc[b] == 15) msat = 1;
      end
      OP_REMOVE: begin
        if (!m) e = 1;
        else begin
          if (mc[a] != 15) mc[a]--;
          if (b != a && mc[b] != 15) mc[b]--;
        end
      end
      OP_CLEAR: begin
        for (int i = 0; i < 32; i++) mc[i] = 0;
        msat = 0;
        m = 0;
      end
      default: ;
    endcase
  endtask

  // Issue one request, check latency and response against the model.
  // hold>0 keeps resp_ready low that many cycles while a new request is pending.
  task automatic do_op(input logic [1:0] op, input logic [31:0] key,
                       input int hold, output int waited);
    int lat;
    bit em, ee;
    waited = 0;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_data  = key;
    if (hold > 0) bus.resp_ready = 1'b0;
    while (!bus.req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.req_ready) begin
      check("accept_timeout", bus.req_ready, 1);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    if (b2b) check("throughput", cyc - last_acc, 4);
    last_acc = cyc;
    lat = 1;
    while (!bus.resp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 3);
    if (!bus.resp_valid) return;
    model_apply(op, key, em, ee);
    check("resp_match", bus.resp_match, em);
    check("resp_err", bus.resp_err, ee);
    check("occupancy", bus.occupancy, mocc());
    check("saturated", bus.saturated, msat);
    $display("[TB] op=%0d key=%08h match=%0b err=%0b occ=%0d sat=%0b",
             op, key, bus.resp_match, bus.resp_err, bus.occupancy, bus.saturated);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_op    = OP_CHECK;
      bus.req_data  = 32'h2;
      check("stall_valid", bus.resp_valid, 1);
      check("stall_match", bus.resp_match, em);
      check("stall_err", bus.resp_err, ee);
      check("stall_req_ready", bus.req_ready, 0);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    check("resp_drop", bus.resp_valid, 0);
    check("idle_ready", bus.req_ready, 1);
  endtask

  initial begin
    int w;
    logic [31:0] pool [10];
    logic [1:0]  rop;
    int          r;

    bus.req_valid  = 1'b0;
    bus.req_op     = OP_CHECK;
    bus.req_data   = '0;
    bus.resp_ready = 1'b1;
    reset_n        = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    check("rst_req_ready", bus.req_ready, 1);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_match", bus.resp_match, 0);
    check("rst_err", bus.resp_err, 0);
    check("rst_occupancy", bus.occupancy, 0);
    check("rst_saturated", bus.saturated, 0);

    do_op(OP_CHECK, 32'h1, 0, w);
    do_op(OP_INSERT, 32'h1, 0, w);
    do_op(OP_CHECK, 32'h1, 0, w);
    check("occ_after_insert1", bus.occupancy, 2);
    do_op(OP_CHECK, 32'h2, 0, w);
    check("false_positive_2", bus.resp_match, 1);

    do_op(OP_INSERT, 32'h3, 0, w);
    check("occ_same_bucket", bus.occupancy, 3);
    do_op(OP_REMOVE, 32'h3, 0, w);
    do_op(OP_REMOVE, 32'h3, 0, w);
    check("remove_missing_err", bus.resp_err, 1);

    repeat (16) do_op(OP_INSERT, 32'h1, 0, w);
    check("sat_after_16", bus.saturated, 1);
    repeat (20) do_op(OP_REMOVE, 32'h1, 0, w);
    check("sat_remove_match", bus.resp_match, 1);
    do_op(OP_CLEAR, 32'h0, 0, w);
    check("clear_occ", bus.occupancy, 0);
    check("clear_sat", bus.saturated, 0);

    do_op(OP_INSERT, 32'h5, 5, w);
    do_op(OP_CHECK, 32'h2, 0, w);
    check("stall_accept_wait", w, 0);

    repeat (16) do_op(OP_INSERT, 32'h1, 0, w);
    bus.req_valid = 1'b1;
    bus.req_op    = OP_INSERT;
    bus.req_data  = 32'h9;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    @(negedge clk);
    check("midop_rst_valid", bus.resp_valid, 0);
    check("midop_rst_ready", bus.req_ready, 1);
    check("midop_rst_occ", bus.occupancy, 0);
    check("midop_rst_sat", bus.saturated, 0);
    do_op(OP_CHECK, 32'h9, 0, w);
    do_op(OP_CHECK, 32'h1, 0, w);

    pool[0] = 32'h1;
    pool[1] = 32'h2;
    pool[2] = 32'h3;
    for (int i = 3; i < 10; i++) pool[i] = $urandom;
    b2b = 0;
    for (int n = 0; n < 160; n++) begin
      r = $urandom_range(0, 99);
      rop = (r < 40) ? OP_INSERT : (r < 70) ? OP_CHECK : (r < 97) ? OP_REMOVE : OP_CLEAR;
      do_op(rop, pool[$urandom_range(0, 9)], 0, w);
      b2b = 1;
    end
    b2b = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
